// File: rtl/sliced_alu_seq_pkg.sv
// rtl/sliced_alu_seq_pkg.sv - mode, function-select and FSM encodings for the sliced ALU
package sliced_alu_seq_pkg;

    localparam logic MODE_LOGIC = 1'b1;
    localparam logic MODE_ARITH = 1'b0;

    // Arithmetic-mode select codes, named after the X+Y they form
    localparam logic [3:0] S_A              = 4'h0;
    localparam logic [3:0] S_A_OR_B         = 4'h1;
    localparam logic [3:0] S_A_OR_NB        = 4'h2;
    localparam logic [3:0] S_ONES           = 4'h3;
    localparam logic [3:0] S_A_ANDNB_PLUS_A = 4'h4;
    localparam logic [3:0] S_AORB_PLUS_ANB  = 4'h5;
    localparam logic [3:0] S_A_MINUS_B      = 4'h6;
    localparam logic [3:0] S_AANDB_MINUS1   = 4'h7;
    localparam logic [3:0] S_A_PLUS_AANDB   = 4'h8;
    localparam logic [3:0] S_A_PLUS_B       = 4'h9;
    localparam logic [3:0] S_AORB_PLUS_AB   = 4'hA;
    localparam logic [3:0] S_AANDB_DEC      = 4'hB;
    localparam logic [3:0] S_A_PLUS_A       = 4'hC;
    localparam logic [3:0] S_AORB_PLUS_A    = 4'hD;
    localparam logic [3:0] S_AORNB_PLUS_A   = 4'hE;
    localparam logic [3:0] S_A_MINUS1       = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sliced_alu_seq_if.sv
// rtl/sliced_alu_seq_if.sv - request/result handshake bundle for the sliced ALU
interface sliced_alu_seq_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o;
    logic             cout;
    logic             zero;

    modport master (
        output in_valid, a, b, s, m, cin, out_ready,
        input  in_ready, out_valid, o, cout, zero
    );

    modport slave (
        input  in_valid, a, b, s, m, cin, out_ready,
        output in_ready, out_valid, o, cout, zero
    );
endinterface

// File: rtl/sliced_alu_seq_slice.sv
// rtl/sliced_alu_seq_slice.sv - one SLICE-bit operand former, lookahead adder and logic unit
module alu_slice
    import sliced_alu_seq_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic [3:0]       i_s,
    input  logic             i_m,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_f,
    output logic             o_cout
);

    logic [SLICE-1:0] w_x, w_y, w_g, w_p, w_sum, w_logic;
    logic [SLICE:0]   w_c;
    logic             w_acc, w_prod;

    always_comb begin
        w_x = i_a;
        w_y = '0;
        case (i_s)
            S_A:              begin w_x = i_a;          w_y = '0;          end
            S_A_OR_B:         begin w_x = i_a | i_b;    w_y = '0;          end
            S_A_OR_NB:        begin w_x = i_a | ~i_b;   w_y = '0;          end
            S_ONES:           begin w_x = '1;           w_y = '0;          end
            S_A_ANDNB_PLUS_A: begin w_x = i_a & ~i_b;   w_y = i_a;         end
            S_AORB_PLUS_ANB:  begin w_x = i_a | i_b;    w_y = i_a & ~i_b;  end
            S_A_MINUS_B:      begin w_x = i_a;          w_y = ~i_b;        end
            S_AANDB_MINUS1:   begin w_x = i_a & i_b;    w_y = '1;          end
            S_A_PLUS_AANDB:   begin w_x = i_a;          w_y = i_a & i_b;   end
            S_A_PLUS_B:       begin w_x = i_a;          w_y = i_b;         end
            S_AORB_PLUS_AB:   begin w_x = i_a | i_b;    w_y = i_a & i_b;   end
            S_AANDB_DEC:      begin w_x = i_a & i_b;    w_y = '1;          end
            S_A_PLUS_A:       begin w_x = i_a;          w_y = i_a;         end
            S_AORB_PLUS_A:    begin w_x = i_a | i_b;    w_y = i_a;         end
            S_AORNB_PLUS_A:   begin w_x = i_a | ~i_b;   w_y = i_a;         end
            default:          begin w_x = i_a;          w_y = '1;          end
        endcase

        w_g = w_x & w_y;
        w_p = w_x ^ w_y;
        w_c = '0;
        w_c[0] = i_cin;
        w_acc  = 1'b0;
        w_prod = 1'b1;
        // Each carry is the flattened sum-of-products g[j]&p[i..j+1] | cin&p[i..0]
        for (int i = 0; i < SLICE; i++) begin
            w_acc  = 1'b0;
            w_prod = 1'b1;
            for (int j = i; j >= 0; j--) begin
                w_acc  = w_acc | (w_g[j] & w_prod);
                w_prod = w_prod & w_p[j];
            end
            w_c[i+1] = w_acc | (i_cin & w_prod);
        end
        w_sum = w_p ^ w_c[SLICE-1:0];

        w_logic = (~i_a &  i_b & {SLICE{~i_s[0]}})
                | (~i_a & ~i_b & {SLICE{~i_s[1]}})
                | ( i_a & ~i_b & {SLICE{ i_s[2]}})
                | ( i_a &  i_b & {SLICE{ i_s[3]}});

        o_f    = (i_m == MODE_LOGIC) ? w_logic : w_sum;
        o_cout = (i_m == MODE_LOGIC) ? 1'b0 : w_c[SLICE];
    end

endmodule

// File: rtl/sliced_alu_seq.sv
// rtl/sliced_alu_seq.sv - multi-cycle ALU that evaluates WIDTH bits one SLICE per cycle
module sliced_alu_seq
    import sliced_alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic              clk,
    input  logic              rst,
    sliced_alu_seq_if.slave   bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_e            r_state, w_next;
    logic [WIDTH-1:0]  r_a, r_b, r_res;
    logic [3:0]        r_s;
    logic              r_m, r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [SLICE-1:0]  w_f;
    logic              w_cout, w_last;

    assign w_last = (r_idx == IDXW'(NSLICE - 1));

    alu_slice #(.SLICE(SLICE)) u_slice (
        .i_a    (r_a[int'(r_idx)*SLICE +: SLICE]),
        .i_b    (r_b[int'(r_idx)*SLICE +: SLICE]),
        .i_s    (r_s),
        .i_m    (r_m),
        .i_cin  (r_carry),
        .o_f    (w_f),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)  w_next = ST_RUN;
            ST_RUN:  if (w_last)        w_next = ST_DONE;
            ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
        endcase
    end

    // r_carry doubles as the captured cin and the inter-slice ripple carry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_m     <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_res   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.in_valid) begin
                    r_a     <= bus.a;
                    r_b     <= bus.b;
                    r_s     <= bus.s;
                    r_m     <= bus.m;
                    r_carry <= bus.cin;
                    r_idx   <= '0;
                end
                ST_RUN: begin
                    r_res[int'(r_idx)*SLICE +: SLICE] <= w_f;
                    r_carry <= w_cout;
                    r_idx   <= w_last ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.o         = r_res;
    assign bus.cout      = r_carry;
    assign bus.zero      = (r_state == ST_DONE) && (r_res == '0);

endmodule

// File: tb/tb_sliced_alu_seq.sv
// tb/tb_sliced_alu_seq.sv - scoreboard bench for sliced_alu_seq at WIDTH 16, 8 and 32
module tb_sliced_alu_seq;

    typedef struct {
        logic [31:0] o;
        logic        co;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ta = '0, tb_b = '0;
    logic [3:0]  ts = '0;
    logic        tm = 1'b0, tcin = 1'b0, tor = 1'b0;
    logic [2:0]  tv = '0;
    int          sel = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];

    logic [31:0] ob;
    logic        vb, cb, zb, rb;

    always #5 clk = ~clk;

    sliced_alu_seq_if #(.WIDTH(16)) if16 ();
    sliced_alu_seq_if #(.WIDTH(8))  if8  ();
    sliced_alu_seq_if #(.WIDTH(32)) if32 ();

    assign if16.a = ta[15:0];  assign if16.b = tb_b[15:0]; assign if16.s = ts;
    assign if16.m = tm;        assign if16.cin = tcin;     assign if16.out_ready = tor;
    assign if16.in_valid = tv[0];
    assign if8.a  = ta[7:0];   assign if8.b  = tb_b[7:0];  assign if8.s  = ts;
    assign if8.m  = tm;        assign if8.cin  = tcin;     assign if8.out_ready  = tor;
    assign if8.in_valid  = tv[1];
    assign if32.a = ta;        assign if32.b = tb_b;       assign if32.s = ts;
    assign if32.m = tm;        assign if32.cin = tcin;     assign if32.out_ready = tor;
    assign if32.in_valid = tv[2];

    sliced_alu_seq #(.WIDTH(16), .SLICE(4)) u16 (.clk(clk), .rst(rst), .bus(if16.slave));
    sliced_alu_seq #(.WIDTH(8),  .SLICE(4)) u8  (.clk(clk), .rst(rst), .bus(if8.slave));
    sliced_alu_seq #(.WIDTH(32), .SLICE(4)) u32 (.clk(clk), .rst(rst), .bus(if32.slave));

    always_comb begin
        ob = '0; vb = 1'b0; cb = 1'b0; zb = 1'b0; rb = 1'b0;
        case (sel)
            1:       begin ob = {24'd0, if8.o};  vb = if8.out_valid;  cb = if8.cout;  zb = if8.zero;  rb = if8.in_ready;  end
            2:       begin ob = if32.o;          vb = if32.out_valid; cb = if32.cout; zb = if32.zero; rb = if32.in_ready; end
            default: begin ob = {16'd0, if16.o}; vb = if16.out_valid; cb = if16.cout; zb = if16.zero; rb = if16.in_ready; end
        endcase
    end

    function automatic int nslice(input int inst);
        return (inst == 1) ? 2 : (inst == 2) ? 8 : 4;
    endfunction

    function automatic int width(input int inst);
        return (inst == 1) ? 8 : (inst == 2) ? 32 : 16;
    endfunction

    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] s, input logic m, input logic cin);
        logic [32:0] mk, av, bv, x, y, sum;
        exp_t e;
        mk = (33'd1 << w) - 33'd1;
        av = {1'b0, a} & mk;
        bv = {1'b0, b} & mk;
        x = '0; y = '0;
        if (m) begin
            x = (~av & bv & {33{~s[0]}}) | (~av & ~bv & {33{~s[1]}})
              | (av & ~bv & {33{s[2]}})  | (av & bv & {33{s[3]}});
            e.o  = 32'(x & mk);
            e.co = 1'b0;
        end else begin
            case (s)
                4'h0: begin x = av;        y = 0;         end
                4'h1: begin x = av | bv;   y = 0;         end
                4'h2: begin x = av | ~bv;  y = 0;         end
                4'h3: begin x = mk;        y = 0;         end
                4'h4: begin x = av & ~bv;  y = av;        end
                4'h5: begin x = av | bv;   y = av & ~bv;  end
                4'h6: begin x = av;        y = ~bv;       end
                4'h7: begin x = av & bv;   y = mk;        end
                4'h8: begin x = av;        y = av & bv;   end
                4'h9: begin x = av;        y = bv;        end
                4'hA: begin x = av | bv;   y = av & bv;   end
                4'hB: begin x = av & bv;   y = mk;        end
                4'hC: begin x = av;        y = av;        end
                4'hD: begin x = av | bv;   y = av;        end
                4'hE: begin x = av | ~bv;  y = av;        end
                default: begin x = av;     y = mk;        end
            endcase
            sum  = (x & mk) + (y & mk) + {32'd0, cin};
            e.o  = 32'(sum & mk);
            e.co = sum[w];
        end
        e.z = (e.o == 32'd0);
        return e;
    endfunction

    task automatic run_op(input int inst, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] s, input logic m, input logic cin, input exp_t e);
        int   cyc;
        exp_t got;
        sel = inst;
        @(negedge clk);
        ta = a; tb_b = b; ts = s; tm = m; tcin = cin;
        q.push_back(e);
        checks++;
        if (rb !== 1'b1) begin errors++; $display("FAIL ready_idle inst%0d got %b exp 1", inst, rb); end
        tv[inst] = 1'b1;
        @(posedge clk); #1;
        tv[inst] = 1'b0;
        checks++;
        if (rb !== 1'b0) begin errors++; $display("FAIL ready_run inst%0d got %b exp 0", inst, rb); end
        cyc = 0;
        while (vb !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (cyc != nslice(inst)) begin errors++; $display("FAIL latency inst%0d got %0d exp %0d", inst, cyc, nslice(inst)); end
        @(negedge clk);
        got = q.pop_front();
        checks++;
        if (ob !== got.o) begin errors++; $display("FAIL result inst%0d m%b s%h got %h exp %h", inst, m, s, ob, got.o); end
        checks++;
        if (cb !== got.co) begin errors++; $display("FAIL cout inst%0d m%b s%h got %b exp %b", inst, m, s, cb, got.co); end
        checks++;
        if (zb !== got.z) begin errors++; $display("FAIL zero inst%0d got %b exp %b", inst, zb, got.z); end
        tor = 1'b1;
        @(posedge clk); #1;
        tor = 1'b0;
        checks++;
        if (rb !== 1'b1 || vb !== 1'b0) begin errors++; $display("FAIL after_handshake inst%0d ready %b valid %b exp 1 0", inst, rb, vb); end
    endtask

    task automatic test_reset;
        sel = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rb !== 1'b0 || vb !== 1'b0 || ob !== 32'd0 || cb !== 1'b0 || zb !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got rdy%b vld%b o%h c%b z%b exp all 0", rb, vb, ob, cb, zb);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rb !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", rb); end
    endtask

    task automatic test_directed;
        exp_t e;
        e.o = 32'h0000; e.co = 1'b1; e.z = 1'b1;
        run_op(0, 32'hFFFF, 32'h0001, 4'h9, 1'b0, 1'b0, e);
        e.o = 32'h1200; e.co = 1'b1; e.z = 1'b0;
        run_op(0, 32'h1234, 32'h0034, 4'h6, 1'b0, 1'b1, e);
        e.o = 32'h0FF0; e.co = 1'b0; e.z = 1'b0;
        run_op(0, 32'hF0F0, 32'hFF00, 4'h6, 1'b1, 1'b1, e);
        e.o = 32'h0FF0; e.co = 1'b0; e.z = 1'b0;
        run_op(0, 32'hF0F0, 32'hFF00, 4'h6, 1'b1, 1'b0, e);
    endtask

    task automatic test_hold_done;
        int   cyc;
        exp_t e;
        sel = 0;
        e.o = 32'h1200; e.co = 1'b1; e.z = 1'b0;
        @(negedge clk);
        ta = 32'h1234; tb_b = 32'h0034; ts = 4'h6; tm = 1'b0; tcin = 1'b1;
        q.push_back(e);
        tv[0] = 1'b1;
        @(posedge clk); #1;
        tv[0] = 1'b0;
        cyc = 0;
        while (vb !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (vb !== 1'b1) begin errors++; $display("FAIL hold_reach_done got %b exp 1", vb); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ta = 32'h0000_ABCD; tb_b = 32'h0; tv[0] = 1'b1;
            checks++;
            if (ob !== q[0].o || cb !== q[0].co || zb !== q[0].z || rb !== 1'b0 || vb !== 1'b1) begin
                errors++; $display("FAIL hold_stable cyc%0d got o%h c%b z%b rdy%b vld%b exp o%h c%b z%b rdy0 vld1",
                                   i, ob, cb, zb, rb, vb, q[0].o, q[0].co, q[0].z);
            end
        end
        @(negedge clk);
        tv[0] = 1'b0;
        tor = 1'b1;
        void'(q.pop_front());
        @(posedge clk); #1;
        tor = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (vb !== 1'b0 || rb !== 1'b1) begin errors++; $display("FAIL hold_ignored_request got vld%b rdy%b exp 0 1", vb, rb); end
    endtask

    task automatic test_reset_abort;
        exp_t e;
        sel = 0;
        @(negedge clk);
        ta = 32'hFFFF; tb_b = 32'hFFFF; ts = 4'h9; tm = 1'b0; tcin = 1'b1;
        tv[0] = 1'b1;
        @(posedge clk); #1;
        tv[0] = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if (rb !== 1'b0 || vb !== 1'b0 || ob !== 32'd0 || cb !== 1'b0 || zb !== 1'b0) begin
            errors++; $display("FAIL abort_outputs got rdy%b vld%b o%h c%b z%b exp all 0", rb, vb, ob, cb, zb);
        end
        @(negedge clk);
        rst = 1'b0;
        e.o = 32'h0006; e.co = 1'b0; e.z = 1'b0;
        run_op(0, 32'h0005, 32'h0000, 4'h0, 1'b0, 1'b1, e);
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic        c;
        for (int inst = 1; inst <= 2; inst++) begin
            for (int code = 0; code < 32; code++) begin
                a = $urandom;
                b = $urandom;
                c = 1'($urandom_range(0, 1));
                run_op(inst, a, b, 4'(code), code[4], c,
                       model(width(inst), a, b, 4'(code), code[4], c));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold_done();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sliced_alu_seq.md
SLICED_ALU_SEQ -- requirements
Module: sliced_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; a multiple of SLICE and at least SLICE.
REQ-002 SHALL have parameter SLICE, default 4, bits processed per cycle; NSLICE = WIDTH/SLICE.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; no other clock or reset.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  operation request.
REQ-007 in_ready  out  1  block can accept a request.
REQ-008 a  in  WIDTH  operand A.
REQ-009 b  in  WIDTH  operand B.
REQ-010 s  in  4  function select.
REQ-011 m  in  1  mode select: 1 = logic, 0 = arithmetic.
REQ-012 cin  in  1  arithmetic carry-in.
REQ-013 out_valid  out  1  result available.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 o  out  WIDTH  result.
REQ-016 cout  out  1  carry out of the MSB slice.
REQ-017 zero  out  1  result equals 0.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE).
REQ-019 IDLE: on in_valid=1, SHALL register a, b, s, m and cin, clear the slice index, and go to RUN.
REQ-020 In IDLE, input changes without in_valid SHALL have no effect.
REQ-021 RUN: each cycle SHALL compute slice k (bits k*SLICE+SLICE-1..k*SLICE), LSB slice first, and write it into the result register.
REQ-022 RUN: the slice carry-out SHALL be registered and used as carry-in of slice k+1; slice 0 uses the captured cin.
REQ-023 After slice NSLICE-1, SHALL go to DONE; out_valid rises exactly NSLICE cycles after the accept edge.
REQ-024 DONE: SHALL hold out_valid=1 and keep o, cout and zero stable until out_ready=1, then return to IDLE on that edge.
REQ-025 in_ready SHALL first be 1 on the cycle after the result handshake; no back-to-back overlap.
REQ-026 Logic mode (m=1), per bit i: o[i] = (~a&b&~s0) | (~a&~b&~s1) | (a&~b&s2) | (a&b&s3); cin is ignored and cout=0.
REQ-027 Arithmetic mode (m=0): o = X+Y+cin, where (X,Y) are selected by s as follows.
- 0:(a,0)  1:(a|b,0)  2:(a|~b,0)  3:(ones,0)
- 4:(a&~b,a)  5:(a|b,a&~b)  6:(a,~b)  7:(a&b,ones)
- 8:(a,a&b)  9:(a,b)  A:(a|b,a&b)  B:(a&b,ones)
- C:(a,a)  D:(a|b,a)  E:(a|~b,a)  F:(a,ones)
REQ-028 Arithmetic SHALL be modulo 2^WIDTH; cout is the carry out of bit WIDTH-1.
REQ-029 zero SHALL be 1 when all WIDTH result bits are 0; it is valid only while out_valid=1.
REQ-030 Each slice adder SHALL be carry-lookahead within the slice and ripple across cycles.
REQ-031 When NSLICE=1, RUN SHALL last one cycle.

Reset
REQ-032 rst=1 SHALL asynchronously force the state to IDLE and clear the result register, carry, slice index and captured operands.
REQ-033 During reset: in_ready=0, out_valid=0, o=0, cout=0, zero=0.
REQ-034 in_ready SHALL be 1 on the first clock edge after rst deasserts.
REQ-035 Reset during RUN or DONE SHALL abort the operation; the partial result SHALL never appear with out_valid=1.

Structure
REQ-036 A shared include file SHALL hold the mode constants (MODE_LOGIC, MODE_ARITH), the 4-bit s code names and the FSM state encodings.
REQ-037 SHALL instantiate one combinational sub-module, alu_slice (SLICE-bit operand forming + CLA + logic function), reused each RUN cycle.
REQ-038 The slice index width SHALL be clog2(NSLICE), with a minimum of 1.

Verification
REQ-039 WIDTH=16, m=0, s=9, a=0xFFFF, b=0x0001, cin=0 -> o=0x0000, cout=1, zero=1; out_valid 4 cycles after accept.
REQ-040 m=0, s=6, a=0x1234, b=0x0034, cin=1 -> o=0x1200 (a-b), cout=1, zero=0.
REQ-041 m=1, s=0x6, a=0xF0F0, b=0xFF00 -> o=0x0FF0 (XOR), cout=0; cin=1 has no effect.
REQ-042 Hold out_ready=0 for 5 cycles in DONE -> o/cout/zero stable, in_ready=0, a new in_valid is ignored.
REQ-043 Assert rst in the 2nd RUN cycle -> all outputs 0 immediately; next operation m=0, s=0, a=0x0005, cin=1 -> o=0x0006.
REQ-044 Randomised check, WIDTH=8 and WIDTH=32, all 32 (m,s) codes vs reference model -> o/cout match, latency = NSLICE.
